// File: rtl/pheap_root_pkg.sv
// Shared priority-queue types: key/value pair, heap entry, opcodes and the ordering helpers.
package pq_pkg;
  localparam int KEY_W = 8;
  localparam int VAL_W = 8;
  localparam int CAP_W = 16;

  localparam logic [KEY_W-1:0] KEY0 = '0;
  localparam logic [VAL_W-1:0] VAL0 = '0;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  typedef struct packed {
    logic             active;
    logic [CAP_W-1:0] capacity;
    kv_t              kv;
  } entry_t;

  // Commands to the level-2 manager
  typedef enum logic [1:0] {
    LENQ  = 2'd0,
    LDEQ  = 2'd1,
    LREPL = 2'd2,
    LNOP  = 2'd3
  } opcode_t;

  // Requests accepted at the root
  typedef enum logic [1:0] {
    ENQ  = 2'd0,
    DEQ  = 2'd1,
    REPL = 2'd2,
    NOP  = 2'd3
  } req_op_t;

  localparam kv_t    KV_EMPTY    = '{key: '1, val: '1};
  localparam entry_t ENTRY_EMPTY = '{active: 1'b0, capacity: '0, kv: '{key: KEY0, val: VAL0}};

  function automatic logic kv_gt(input kv_t a, input kv_t b);
    return a.key > b.key;
  endfunction

  // An inactive entry orders below every active one
  function automatic logic entry_gt(input entry_t a, input entry_t b);
    if (!a.active) return 1'b0;
    if (!b.active) return 1'b1;
    return kv_gt(a.kv, b.kv);
  endfunction
endpackage

// File: rtl/pheap_root_if.sv
// Request/response channel of the heap root: request handshake, result pulse and error pulse.
interface pheap_root_if;
  import pq_pkg::*;

  logic    req_valid;
  req_op_t req_op;
  kv_t     req_kv;
  logic    req_ready;
  logic    resp_valid;
  kv_t     resp_kv;
  logic    err;

  modport master (
    output req_valid, req_op, req_kv,
    input  req_ready, resp_valid, resp_kv, err
  );

  modport slave (
    input  req_valid, req_op, req_kv,
    output req_ready, resp_valid, resp_kv, err
  );
endinterface

// File: rtl/pheap_root_sel.sv
// Combinational child selection and key ordering for the heap root.
// The replace outputs exist only when PHEAP_REPL_EN is defined.
module pheap_root_sel
  import pq_pkg::*;
(
  input  kv_t    in_kv,
  input  kv_t    root_kv,
  input  entry_t bot_l,
  input  entry_t bot_r,
  output logic   enq_pos,
  output logic   big_pos,
  output logic   any_child,
  output kv_t    big_kv,
  output kv_t    enq_keep,
  output kv_t    enq_push
`ifdef PHEAP_REPL_EN
  ,
  output kv_t    repl_kv,
  output logic   repl_start
`endif
);

  // Fill empty slots right-first, then steer toward the smaller subtree that still has room
  always_comb begin
    enq_pos = 1'b1;
    if (bot_r.active) begin
      if (!bot_l.active)
        enq_pos = 1'b0;
      else if ((bot_l.capacity != '0) && (bot_r.capacity != '0))
        enq_pos = entry_gt(bot_l, bot_r);
      else
        enq_pos = (bot_l.capacity == '0);
    end
  end

  assign big_pos   = entry_gt(bot_r, bot_l);
  assign big_kv    = big_pos ? bot_r.kv : bot_l.kv;
  assign any_child = bot_l.active | bot_r.active;
  assign enq_keep  = kv_gt(in_kv, root_kv) ? in_kv : root_kv;
  assign enq_push  = kv_gt(in_kv, root_kv) ? root_kv : in_kv;

`ifdef PHEAP_REPL_EN
  logic in_wins;
  assign in_wins    = (!bot_l.active || kv_gt(in_kv, bot_l.kv)) &&
                      (!bot_r.active || kv_gt(in_kv, bot_r.kv));
  assign repl_kv    = in_wins ? in_kv : big_kv;
  assign repl_start = !in_wins;
`endif

endmodule

// File: rtl/pheap_root.sv
// Root stage of the pipelined max-heap: register-held root entry, level-2 manager kick-off.
// PHEAP_REPL_EN enables the replace request; without it REPL only pulses err.
module pheap_root
  import pq_pkg::*;
#(
  parameter int LEVELS = 4
) (
  input  logic            clk,
  input  logic            rst,
  pheap_root_if.slave     bus,
  output logic            full,
  output logic            empty,
  output logic [LEVELS:0] count,
  input  entry_t          rBotL,
  input  entry_t          rBotR,
  output logic            start,
  output opcode_t         op,
  output kv_t             out,
  output logic            startPos
);

  localparam int               CAP_MAX    = 2**LEVELS - 1;
  localparam logic [CAP_W-1:0] CAP_FULL   = CAP_W'(CAP_MAX);
  localparam logic [CAP_W-1:0] CAP_ONE    = CAP_W'(1);
  localparam logic [LEVELS:0]  COUNT_FULL = (LEVELS+1)'(CAP_MAX);
  localparam logic [LEVELS:0]  COUNT_ONE  = (LEVELS+1)'(1);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t  state;
  entry_t  root;
  req_op_t req_op_p0;
  kv_t     req_kv_p0;

  logic enq_pos, big_pos, any_child;
  kv_t  big_kv, enq_keep, enq_push;
`ifdef PHEAP_REPL_EN
  kv_t  repl_kv;
  logic repl_start;
`endif

  pheap_root_sel u_sel (
    .in_kv     (req_kv_p0),
    .root_kv   (root.kv),
    .bot_l     (rBotL),
    .bot_r     (rBotR),
    .enq_pos   (enq_pos),
    .big_pos   (big_pos),
    .any_child (any_child),
    .big_kv    (big_kv),
    .enq_keep  (enq_keep),
    .enq_push  (enq_push)
`ifdef PHEAP_REPL_EN
    ,
    .repl_kv   (repl_kv),
    .repl_start(repl_start)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      root           <= '{active: 1'b0, capacity: CAP_FULL, kv: '{key: KEY0, val: VAL0}};
      count          <= '0;
      full           <= 1'b0;
      empty          <= 1'b1;
      start          <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.err        <= 1'b0;
      bus.resp_kv    <= KV_EMPTY;
      out            <= KV_EMPTY;
    end else begin
      start          <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.err        <= 1'b0;
      case (state)
        // Stage p0: capture the accepted request
        IDLE: begin
          if (bus.req_valid) begin
            req_op_p0     <= bus.req_op;
            req_kv_p0     <= bus.req_kv;
            state         <= EXEC;
            bus.req_ready <= 1'b0;
          end
        end
        // Evaluate against the root and the level-2 children read this cycle
        EXEC: begin
          state <= HOLD;
          case (req_op_p0)
            ENQ: begin
              if (full) begin
                bus.err <= 1'b1;
              end else begin
                count <= count + COUNT_ONE;
                full  <= ((count + COUNT_ONE) == COUNT_FULL);
                empty <= 1'b0;
                if (!root.active) begin
                  root <= '{active: 1'b1, capacity: CAP_FULL - CAP_ONE, kv: req_kv_p0};
                end else begin
                  root.kv  <= enq_keep;
                  out      <= enq_push;
                  start    <= 1'b1;
                  op       <= LENQ;
                  startPos <= enq_pos;
                  if (root.capacity != '0)
                    root.capacity <= root.capacity - CAP_ONE;
                end
              end
            end
            DEQ: begin
              bus.resp_valid <= 1'b1;
              if (empty) begin
                bus.err     <= 1'b1;
                bus.resp_kv <= KV_EMPTY;
              end else begin
                bus.resp_kv   <= root.kv;
                root.capacity <= root.capacity + CAP_ONE;
                count         <= count - COUNT_ONE;
                full          <= 1'b0;
                empty         <= (count == COUNT_ONE);
                if (!any_child) begin
                  root.active <= 1'b0;
                  root.kv     <= '{key: KEY0, val: VAL0};
                end else begin
                  root.kv  <= big_kv;
                  start    <= 1'b1;
                  op       <= LDEQ;
                  startPos <= big_pos;
                end
              end
            end
            REPL: begin
`ifdef PHEAP_REPL_EN
              bus.resp_valid <= 1'b1;
              if (empty) begin
                bus.err     <= 1'b1;
                bus.resp_kv <= KV_EMPTY;
              end else begin
                bus.resp_kv <= root.kv;
                root.kv     <= repl_kv;
                if (repl_start) begin
                  out      <= req_kv_p0;
                  start    <= 1'b1;
                  op       <= LREPL;
                  startPos <= big_pos;
                end
              end
`else
              bus.err <= 1'b1;
`endif
            end
            default: ;
          endcase
        end
        // Pulses are visible here; level 2 reads settle before the next accept
        HOLD: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pheap_root.sv
// Directed bench for pheap_root at LEVELS=2; REPL expectations follow PHEAP_REPL_EN.
module tb_pheap_root;
  import pq_pkg::*;

  localparam int LEVELS = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            full, empty;
  logic [LEVELS:0] count;
  entry_t          rBotL, rBotR;
  logic            start, startPos;
  opcode_t         op;
  kv_t             out;

  int n_cmp = 0;
  int n_bad = 0;

  logic    o_start, o_pos, o_rv, o_err;
  opcode_t o_op;
  kv_t     o_out, o_rkv;
  kv_t     root_exp;

  pheap_root_if bus ();

  pheap_root #(.LEVELS(LEVELS)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .rBotL   (rBotL),
    .rBotR   (rBotR),
    .start   (start),
    .op      (op),
    .out     (out),
    .startPos(startPos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  function automatic kv_t mk(input logic [7:0] k);
    return '{key: k, val: ~k};
  endfunction

  function automatic entry_t ent(input logic [7:0] k, input logic [15:0] cap);
    return '{active: 1'b1, capacity: cap, kv: mk(k)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One request from IDLE; captures the pulse cycle and checks pulses drop afterwards
  task automatic issue(input req_op_t rop, input kv_t kv, input string tag);
    @(negedge clk);
    check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = rop;
    bus.req_kv    = kv;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    o_start = start;
    o_op    = op;
    o_out   = out;
    o_pos   = startPos;
    o_rv    = bus.resp_valid;
    o_rkv   = bus.resp_kv;
    o_err   = bus.err;
    @(posedge clk); #1;
    check({tag, " one-cycle"}, 32'({start, bus.resp_valid, bus.err}), 32'd0);
  endtask

  initial begin
    int acc[4];
    int stc[4];
    int n_acc, n_st, n_err;

    bus.req_valid = 1'b0;
    bus.req_op    = ENQ;
    bus.req_kv    = mk(0);
    rBotL         = ENTRY_EMPTY;
    rBotR         = ENTRY_EMPTY;

    // Reset state
    do_reset();
    check("rst ready", 32'(bus.req_ready), 32'd1);
    check("rst count", 32'(count), 32'd0);
    check("rst empty/full", 32'({empty, full}), 32'b10);
    check("rst pulses", 32'({start, bus.resp_valid, bus.err}), 32'd0);
    check("rst resp_kv", 32'(bus.resp_kv), 32'hFFFF);
    check("rst out", 32'(out), 32'hFFFF);
    check("rst root active", 32'(dut.root.active), 32'd0);
    check("rst root cap", 32'(dut.root.capacity), 32'd3);

    // ENQ into an empty root
    issue(ENQ, mk(5), "enq5");
    check("enq5 start", 32'(o_start), 32'd0);
    check("enq5 count", 32'(count), 32'd1);
    check("enq5 root kv", 32'(dut.root.kv), 32'(mk(5)));
    check("enq5 root cap", 32'(dut.root.capacity), 32'd2);
    check("enq5 empty", 32'(empty), 32'd0);

    // ENQ a larger key: it takes the root, the old root is pushed right
    issue(ENQ, mk(9), "enq9");
    check("enq9 start", 32'(o_start), 32'd1);
    check("enq9 op", 32'(o_op), 32'(LENQ));
    check("enq9 out", 32'(o_out), 32'(mk(5)));
    check("enq9 pos", 32'(o_pos), 32'd1);
    check("enq9 count", 32'(count), 32'd2);
    check("enq9 root kv", 32'(dut.root.kv), 32'(mk(9)));
    check("enq9 root cap", 32'(dut.root.capacity), 32'd1);

    // DEQ with children {5,3}
    rBotL = ent(5, 1);
    rBotR = ent(3, 1);
    issue(DEQ, mk(0), "deq");
    check("deq resp_valid", 32'(o_rv), 32'd1);
    check("deq err", 32'(o_err), 32'd0);
    check("deq resp_kv", 32'(o_rkv), 32'(mk(9)));
    check("deq root kv", 32'(dut.root.kv), 32'(mk(5)));
    check("deq start", 32'(o_start), 32'd1);
    check("deq op", 32'(o_op), 32'(LDEQ));
    check("deq pos", 32'(o_pos), 32'd0);
    check("deq count", 32'(count), 32'd1);
    check("deq root cap", 32'(dut.root.capacity), 32'd2);

    // ENQ with both children active and room: goes toward the smaller child
    issue(ENQ, mk(9), "enq9b");
    check("enq9b out", 32'(o_out), 32'(mk(5)));
    check("enq9b pos", 32'(o_pos), 32'd1);
    check("enq9b root kv", 32'(dut.root.kv), 32'(mk(9)));
    check("enq9b count", 32'(count), 32'd2);

`ifdef PHEAP_REPL_EN
    issue(REPL, mk(7), "repl7a");
    check("repl7a resp_valid", 32'(o_rv), 32'd1);
    check("repl7a resp_kv", 32'(o_rkv), 32'(mk(9)));
    check("repl7a root kv", 32'(dut.root.kv), 32'(mk(7)));
    check("repl7a start", 32'(o_start), 32'd0);
    check("repl7a count", 32'(count), 32'd2);
    rBotL = ent(8, 1);
    issue(REPL, mk(7), "repl7b");
    check("repl7b resp_kv", 32'(o_rkv), 32'(mk(7)));
    check("repl7b root kv", 32'(dut.root.kv), 32'(mk(8)));
    check("repl7b out", 32'(o_out), 32'(mk(7)));
    check("repl7b start", 32'(o_start), 32'd1);
    check("repl7b op", 32'(o_op), 32'(LREPL));
    check("repl7b pos", 32'(o_pos), 32'd0);
    root_exp = mk(8);
`else
    issue(REPL, mk(7), "repl-off");
    check("repl-off err", 32'(o_err), 32'd1);
    check("repl-off resp_valid", 32'(o_rv), 32'd0);
    check("repl-off start", 32'(o_start), 32'd0);
    check("repl-off root kv", 32'(dut.root.kv), 32'(mk(9)));
    check("repl-off count", 32'(count), 32'd2);
    root_exp = mk(9);
`endif

    // Left child has no room: ENQ steers right even though left is smaller
    rBotL = ent(2, 0);
    rBotR = ent(6, 1);
    issue(ENQ, mk(4), "enq4");
    check("enq4 out", 32'(o_out), 32'(mk(4)));
    check("enq4 pos", 32'(o_pos), 32'd1);
    check("enq4 root kv", 32'(dut.root.kv), 32'(root_exp));
    check("enq4 count/full", 32'({count, full}), 32'({3'd3, 1'b1}));
    check("enq4 root cap", 32'(dut.root.capacity), 32'd0);

    // ENQ when full
    issue(ENQ, mk(1), "enqfull");
    check("enqfull err", 32'(o_err), 32'd1);
    check("enqfull start/rv", 32'({o_start, o_rv}), 32'd0);
    check("enqfull count", 32'(count), 32'd3);
    check("enqfull root kv", 32'(dut.root.kv), 32'(root_exp));

    // DEQ when empty
    do_reset();
    rBotL = ENTRY_EMPTY;
    rBotR = ENTRY_EMPTY;
    issue(DEQ, mk(0), "deqempty");
    check("deqempty err/rv", 32'({o_err, o_rv}), 32'b11);
    check("deqempty resp_kv", 32'(o_rkv), 32'hFFFF);
    check("deqempty start", 32'(o_start), 32'd0);
    check("deqempty count/empty", 32'({count, empty}), 32'({3'd0, 1'b1}));

    // Right child active, left free: ENQ steers left
    issue(ENQ, mk(5), "enq5c");
    rBotR = ent(3, 1);
    issue(ENQ, mk(9), "enqleft");
    check("enqleft start", 32'(o_start), 32'd1);
    check("enqleft pos", 32'(o_pos), 32'd0);

    // Back-to-back ENQs with req_valid held high
    do_reset();
    rBotL = ENTRY_EMPTY;
    rBotR = ENTRY_EMPTY;
    acc   = '{0, 0, 0, 0};
    stc   = '{0, 0, 0, 0};
    n_acc = 0;
    n_st  = 0;
    n_err = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = ENQ;
    bus.req_kv    = mk(4);
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (start && n_st < 4) begin
        stc[n_st] = cyc;
        n_st++;
      end
      if (bus.err) n_err++;
      if (bus.req_valid && bus.req_ready && n_acc < 4) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
      @(posedge clk); #1;
      if (n_acc == 4) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b accepts", 32'(n_acc), 32'd4);
    check("b2b ready period 1", 32'(acc[1] - acc[0]), 32'd3);
    check("b2b ready period 2", 32'(acc[2] - acc[1]), 32'd3);
    check("b2b ready period 3", 32'(acc[3] - acc[2]), 32'd3);
    check("b2b starts", 32'(n_st), 32'd2);
    check("b2b start spacing", 32'(stc[1] - stc[0]), 32'd3);
    check("b2b start latency", 32'(stc[0] - acc[1]), 32'd2);
    check("b2b err count", 32'(n_err), 32'd1);
    check("b2b count", 32'(count), 32'd3);

    // Reset while a request is in EXEC aborts it
    do_reset();
    issue(ENQ, mk(5), "pre-abort");
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = ENQ;
    bus.req_kv    = mk(9);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort pulses", 32'({start, bus.resp_valid, bus.err}), 32'd0);
    check("abort count", 32'(count), 32'd0);
    check("abort root active", 32'(dut.root.active), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort after start", 32'(start), 32'd0);
    check("abort after ready", 32'(bus.req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
